max_pool_frame_buf: RTL

MAX_POOL_FRAME_BUF -- requirements
Module: max_pool_frame_buf

---
 rtl/max_pool_frame_buf.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/max_pool_frame_buf.sv
// max_pool_frame_buf: binary 2x2 max-pool stage feeding a ping-pong frame
// buffer. Pooled cells are written in raster order into one bank while the
// other bank streams out under valid/ready flow control. A frame that finds
// no free bank at its first window is dropped whole and flagged in overflow.
module max_pool_frame_buf #(
   parameter int OUT_W = 13,
   parameter int OUT_H = 13,
   localparam int N        = OUT_W * OUT_H,
   localparam int IDX_BITS = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                valid_in,
   input  logic                pixel_0,
   input  logic                pixel_1,
   input  logic                pixel_2,
   input  logic                pixel_3,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                out_data,
   output logic [IDX_BITS-1:0] out_idx,
   output logic                out_last,
   output logic                overflow
);

   localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(N - 1);

   typedef enum logic {IDLE, STREAM} rd_state_t;

   logic [N-1:0]        bank_mem [2];
   logic [1:0]          bank_full;
   logic [1:0]          bank_full_nxt;
   logic                wr_bank;
   logic                rd_bank;
   logic                discard;
   logic [IDX_BITS-1:0] wr_idx;
   logic [IDX_BITS-1:0] rd_idx;
   logic [IDX_BITS-1:0] rd_nxt;
   rd_state_t           rd_state;
   logic                full_seen_p0;
   logic                pool_cell;
   logic                handshake;
   logic                rd_release;
   logic                frame_start;
   logic                discard_now;
   logic                wr_en;
   logic                wr_at_last;
   logic                wr_commit;
   logic                wr_drop;

   // Per-edge decisions shared by the write side, bank flags and reader
   always_comb begin
      pool_cell   = pixel_0 | pixel_1 | pixel_2 | pixel_3;
      handshake   = out_valid & out_ready;
      rd_release  = handshake && (rd_idx == LAST_IDX);
      frame_start = valid_in && (wr_idx == '0);
      // A full target bank is still usable if the reader frees it on this same edge
      discard_now = frame_start ? (bank_full[wr_bank] && !(rd_release && (rd_bank == wr_bank)))
                                : discard;
      wr_en       = valid_in && !discard_now;
      wr_at_last  = valid_in && (wr_idx == LAST_IDX);
      wr_commit   = wr_at_last && !discard_now;
      wr_drop     = wr_at_last && discard_now;
      rd_nxt      = rd_idx + 1'b1;
      bank_full_nxt = bank_full;
      if (rd_release) bank_full_nxt[rd_bank] = 1'b0;
      if (wr_commit)  bank_full_nxt[wr_bank] = 1'b1;
   end

   // Write-side control: window counter, bank selection, discard and overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx    <= '0;
         wr_bank   <= 1'b0;
         discard   <= 1'b0;
         overflow  <= 1'b0;
         bank_full <= 2'b00;
      end else begin
         bank_full <= bank_full_nxt;
         if (valid_in) begin
            wr_idx  <= (wr_idx == LAST_IDX) ? '0 : wr_idx + 1'b1;
            discard <= discard_now;
         end
         if (wr_commit) wr_bank <= ~wr_bank;
         if (wr_drop) begin
            overflow <= 1'b1;
            discard  <= 1'b0;
         end
      end
   end

   // Bank storage; contents are don't-care until written, so no reset
   always_ff @(posedge clk) begin
      if (wr_en) bank_mem[wr_bank][wr_idx] <= pool_cell;
   end

   // Read FSM: a full bank is noticed one cycle before streaming starts
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state     <= IDLE;
         rd_idx       <= '0;
         rd_bank      <= 1'b0;
         full_seen_p0 <= 1'b0;
         out_valid    <= 1'b0;
         out_data     <= 1'b0;
         out_idx      <= '0;
         out_last     <= 1'b0;
      end else begin
         case (rd_state)
            IDLE: begin
               full_seen_p0 <= !full_seen_p0 && bank_full[rd_bank];
               if (full_seen_p0) begin
                  rd_state  <= STREAM;
                  rd_idx    <= '0;
                  out_valid <= 1'b1;
                  out_data  <= bank_mem[rd_bank][0];
                  out_idx   <= '0;
                  out_last  <= (LAST_IDX == '0);
               end
            end
            STREAM: begin
               full_seen_p0 <= 1'b0;
               if (handshake) begin
                  if (rd_idx == LAST_IDX) begin
                     rd_bank   <= ~rd_bank;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                     rd_state  <= IDLE;
                  end else begin
                     rd_idx   <= rd_nxt;
                     out_data <= bank_mem[rd_bank][rd_nxt];
                     out_idx  <= rd_nxt;
                     out_last <= (rd_nxt == LAST_IDX);
                  end
               end
            end
            default: rd_state <= IDLE;
         endcase
      end
   end

endmodule
